// File: rtl/stream_demux4_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
package demux_pkg;
  localparam int N_CH = 4;

  typedef enum logic {ST_IDLE, ST_PKT} demux_state_t;
endpackage

// File: rtl/stream_demux4_if.sv
// Input stream plus the four output streams of the demux; slave is the demux side.
interface stream_demux4_if #(parameter int W = 8);
  import demux_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic [W-1:0]        s_data;
  logic [1:0]          s_dest;
  logic                s_last;
  logic [N_CH-1:0]     m_valid;
  logic [N_CH-1:0]     m_ready;
  logic [N_CH*W-1:0]   m_data;
  logic [N_CH-1:0]     m_last;

  modport slave (
    input  s_valid, s_data, s_dest, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, s_dest, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/stream_demux4_out_slot.sv
// One-entry output register slice; holds a beat until the consumer takes it.
module demux_out_slot #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_last,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_last,
  output logic         o_free
);
  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_last;

  // Load wins over drain so a same-edge drain-and-refill keeps valid high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_free  = ~r_valid | i_ready;
endmodule

// File: rtl/stream_demux4.sv
// 1-to-4 packet demux: route picked on a packet's first beat and held to its last beat.
module stream_demux4
  import demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  stream_demux4_if.slave              bus,
  output logic [N_CH-1:0][CNT_W-1:0]  o_pkt_cnt,
  output logic                        o_dest_err
);
  demux_state_t              r_state;
  logic [1:0]                r_cur_dest;
  logic                      r_dest_err;
  logic [N_CH-1:0][CNT_W-1:0] r_cnt;

  logic [1:0]                w_route;
  logic                      w_acc;
  logic [N_CH-1:0]           w_load;
  logic [N_CH-1:0]           w_free;
  logic [N_CH-1:0]           w_valid;
  logic [N_CH-1:0]           w_last;
  logic [N_CH-1:0][W-1:0]    w_data;

  assign w_route     = (r_state == ST_PKT) ? r_cur_dest : bus.s_dest;
  assign bus.s_ready = w_free[w_route];
  assign w_acc       = bus.s_valid & bus.s_ready;

  always_comb begin
    w_load = '0;
    w_load[w_route] = w_acc;
  end

  demux_out_slot #(.W(W)) u_slot [N_CH-1:0] (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_data  (bus.s_data),
    .i_last  (bus.s_last),
    .i_ready (bus.m_ready),
    .o_valid (w_valid),
    .o_data  (w_data),
    .o_last  (w_last),
    .o_free  (w_free)
  );

  assign bus.m_valid = w_valid;
  assign bus.m_data  = w_data;
  assign bus.m_last  = w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cur_dest <= 2'd0;
      r_dest_err <= 1'b0;
    end else if (w_acc) begin
      if (r_state == ST_IDLE) begin
        if (!bus.s_last) begin
          r_state    <= ST_PKT;
          r_cur_dest <= bus.s_dest;
        end
      end else begin
        if (bus.s_dest != r_cur_dest) r_dest_err <= 1'b1;
        if (bus.s_last)               r_state    <= ST_IDLE;
      end
    end
  end

  // Completed packets counted on the output side; saturate rather than wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (w_valid[k] && bus.m_ready[k] && w_last[k] && (r_cnt[k] != {CNT_W{1'b1}}))
          r_cnt[k] <= r_cnt[k] + 1'b1;
      end
    end
  end

  assign o_pkt_cnt  = r_cnt;
  assign o_dest_err = r_dest_err;
endmodule

// File: tb/tb_stream_demux4.sv
// Randomised + directed bench for stream_demux4 against a queue-based channel model.
module tb_stream_demux4;
  import demux_pkg::*;

  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [N_CH-1:0][CNT_W-1:0] pkt_cnt;
  logic dest_err;

  stream_demux4_if #(.W(W)) bus ();

  stream_demux4 #(.W(W), .CNT_W(CNT_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus.slave),
    .o_pkt_cnt  (pkt_cnt),
    .o_dest_err (dest_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int steps    = 0;

  // Reference model: one queue per channel (depth never exceeds one), packet state, counters.
  beat_t q [N_CH][$];
  int    mdl_cnt [N_CH];
  logic  mdl_err;
  logic  mdl_in_pkt;
  logic [1:0] mdl_dest;
  logic  acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int k = 0; k < N_CH; k++) begin
      q[k].delete();
      mdl_cnt[k] = 0;
    end
    mdl_err    = 1'b0;
    mdl_in_pkt = 1'b0;
    mdl_dest   = 2'd0;
    acc        = 1'b0;
  endtask

  // One clock: compare at negedge, advance model with this cycle's handshakes, return #1 after posedge.
  task automatic step();
    logic [1:0] rt;
    logic       er;
    beat_t      b;
    @(negedge clk);
    rt = mdl_in_pkt ? mdl_dest : bus.s_dest;
    er = (q[rt].size() == 0) || bus.m_ready[rt];
    chk("s_ready", {31'd0, bus.s_ready}, {31'd0, er});
    chk("dest_err", {31'd0, dest_err}, {31'd0, mdl_err});
    for (int k = 0; k < N_CH; k++) begin
      chk($sformatf("m_valid%0d", k), {31'd0, bus.m_valid[k]}, (q[k].size() != 0) ? 32'd1 : 32'd0);
      chk($sformatf("pkt_cnt%0d", k), {28'd0, pkt_cnt[k]}, mdl_cnt[k]);
      if (q[k].size() != 0) begin
        chk($sformatf("m_data%0d", k), {24'd0, bus.m_data[k*W +: W]}, {24'd0, q[k][0].d});
        chk($sformatf("m_last%0d", k), {31'd0, bus.m_last[k]}, {31'd0, q[k][0].l});
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      if (q[k].size() != 0 && bus.m_ready[k]) begin
        b = q[k].pop_front();
        if (b.l && mdl_cnt[k] < CMAX) mdl_cnt[k]++;
      end
    end
    acc = bus.s_valid && er;
    if (acc) begin
      b.d = bus.s_data;
      b.l = bus.s_last;
      q[rt].push_back(b);
      if (mdl_in_pkt && bus.s_dest != mdl_dest) mdl_err = 1'b1;
      if (bus.s_last)       mdl_in_pkt = 1'b0;
      else if (!mdl_in_pkt) begin
        mdl_in_pkt = 1'b1;
        mdl_dest   = bus.s_dest;
      end
    end
    steps++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic [1:0] dst, input logic l);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_dest  = dst;
    bus.s_last  = l;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) step();
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) step();
  endtask

  int t0;

  initial begin
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_dest  = 2'd0;
    bus.s_last  = 1'b0;
    bus.m_ready = 4'hF;
    mdl_reset();

    // 1: reset state
    #3;
    chk("rst_m_valid", {28'd0, bus.m_valid}, 32'd0);
    chk("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    chk("rst_dest_err", {31'd0, dest_err}, 32'd0);
    chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2: single-beat packets to each channel
    for (int k = 0; k < N_CH; k++) send_beat(8'hA0 + 8'(k), 2'(k), 1'b1);
    idle(2);
    for (int k = 0; k < N_CH; k++) chk($sformatf("t2_cnt%0d", k), {28'd0, pkt_cnt[k]}, 32'd1);

    // 3: dest changes mid-packet; all beats must stay on ch2
    send_beat(8'h20, 2'd2, 1'b0);
    send_beat(8'h21, 2'd2, 1'b0);
    send_beat(8'h22, 2'd1, 1'b0);
    send_beat(8'h23, 2'd2, 1'b1);
    idle(2);
    chk("t3_dest_err", {31'd0, dest_err}, 32'd1);
    chk("t3_cnt1", {28'd0, pkt_cnt[1]}, 32'd1);
    chk("t3_cnt2", {28'd0, pkt_cnt[2]}, 32'd2);

    // 4: ch1 backpressure stalls input while ch3 drains on its own
    bus.m_ready = 4'b0101;
    send_beat(8'h30, 2'd3, 1'b1);
    send_beat(8'h10, 2'd1, 1'b1);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h11;
    bus.s_dest  = 2'd1;
    bus.s_last  = 1'b1;
    step();
    chk("t4_stall0", {31'd0, bus.s_ready}, 32'd0);
    bus.m_ready = 4'b1101;
    step();
    step();
    chk("t4_stall1", {31'd0, bus.s_ready}, 32'd0);
    chk("t4_ch3_drained", {31'd0, bus.m_valid[3]}, 32'd0);
    bus.m_ready = 4'hF;
    send_beat(8'h11, 2'd1, 1'b1);
    send_beat(8'h31, 2'd3, 1'b0);
    send_beat(8'h32, 2'd3, 1'b1);
    idle(2);

    // 5: back-to-back stream, then with a 1-cycle downstream stall
    t0 = steps;
    for (int i = 0; i < 8; i++) send_beat(8'h50 + 8'(i), 2'd0, (i == 7));
    chk("t5_cycles", steps - t0, 32'd8);
    t0 = steps;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        bus.m_ready = 4'b1110;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h65;
        bus.s_dest  = 2'd0;
        bus.s_last  = 1'b0;
        step();
        bus.m_ready = 4'hF;
      end
      send_beat(8'h60 + 8'(i), 2'd0, (i == 7));
    end
    chk("t5_stall_cycles", steps - t0, 32'd9);
    idle(2);

    // 6: reset mid-packet with ch3 slot full
    bus.m_ready = 4'b0111;
    send_beat(8'h70, 2'd3, 1'b0);
    bus.s_data = 8'h71;
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_m_valid", {28'd0, bus.m_valid}, 32'd0);
    chk("t6_dest_err", {31'd0, dest_err}, 32'd0);
    mdl_reset();
    bus.s_valid = 1'b0;
    bus.m_ready = 4'hF;
    #1;
    rst_n = 1'b1;
    send_beat(8'h55, 2'd1, 1'b1);
    idle(2);
    chk("t6_cnt1", {28'd0, pkt_cnt[1]}, 32'd1);
    chk("t6_cnt3", {28'd0, pkt_cnt[3]}, 32'd0);

    // Random traffic: holds beats until accepted, rare mid-packet dest changes
    acc = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!bus.s_valid || acc) begin
        bus.s_valid = ($urandom % 10) < 7;
        bus.s_data  = W'($urandom);
        bus.s_last  = ($urandom % 10) < 3;
        if (mdl_in_pkt && ($urandom % 30) != 0) bus.s_dest = mdl_dest;
        else                                   bus.s_dest = 2'($urandom);
      end
      for (int k = 0; k < N_CH; k++) bus.m_ready[k] = ($urandom % 4) != 0;
      step();
    end
    bus.m_ready = 4'hF;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
